// File: rtl/arpeggiator.sv
// Arpeggiator: turns a set of held keys into a sequence of single notes.
//
// Ports:
//   CLK         - system clock, all state updates on the rising edge
//   RESET       - asynchronous active-high reset
//   key0..key7  - key-held flags (key0 lowest note, key7 highest)
//   Enable      - 1 = arpeggiate, 0 = pass keys straight through
//   PingPongEn  - 1 = up/down bounce, 0 = upward wrap
//   countermax  - note-hold length; each note lasts countermax+1 cycles
//   out0..out7  - note-on flags to the voice stage
//
// Curr_State holds the index of the sounding key (0..7) or IDLE (8).
module arpeggiator (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        key0,
  input  logic        key1,
  input  logic        key2,
  input  logic        key3,
  input  logic        key4,
  input  logic        key5,
  input  logic        key6,
  input  logic        key7,
  input  logic        Enable,
  input  logic        PingPongEn,
  input  logic [15:0] countermax,
  output logic        out0,
  output logic        out1,
  output logic        out2,
  output logic        out3,
  output logic        out4,
  output logic        out5,
  output logic        out6,
  output logic        out7
);

  localparam logic [3:0] NOTE0 = 4'd0;
  localparam logic [3:0] IDLE  = 4'd8;

  logic on0, on1, on2, on3, on4, on5, on6, on7;
  logic [7:0]  keys;
  logic [3:0]  Curr_State, Next_State;
  logic [15:0] counter, counter_next;
  logic        dir, dir_next;

  logic [2:0] n;
  logic       any_held;
  logic       up_found, dn_found;
  logic [2:0] up_idx, dn_idx, lo_idx;
  logic [7:0] out_vec;

  assign on0 = key0;
  assign on1 = key1;
  assign on2 = key2;
  assign on3 = key3;
  assign on4 = key4;
  assign on5 = key5;
  assign on6 = key6;
  assign on7 = key7;
  assign keys = {on7, on6, on5, on4, on3, on2, on1, on0};

  assign n        = Curr_State[2:0];
  assign any_held = |keys;

  // Nearest held key above n, nearest below n, and lowest held key overall.
  // Scan order makes the last hit the nearest one.
  always_comb begin
    up_found = 1'b0;
    up_idx   = 3'd0;
    dn_found = 1'b0;
    dn_idx   = 3'd0;
    lo_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (keys[i] && (i > int'(n))) begin
        up_found = 1'b1;
        up_idx   = 3'(i);
      end
      if (keys[i]) begin
        lo_idx = 3'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (keys[i] && (i < int'(n))) begin
        dn_found = 1'b1;
        dn_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    Next_State   = Curr_State;
    counter_next = counter;
    dir_next     = dir;
    if (!Enable) begin
      Next_State   = IDLE;
      counter_next = 16'd0;
      dir_next     = 1'b0;
    end else if (Curr_State[3]) begin
      // IDLE (and any unused encoding): start from the lowest held key.
      if (any_held) begin
        Next_State   = {1'b0, lo_idx};
        counter_next = 16'd0;
        dir_next     = 1'b0;
      end
    end else if (keys[n] && (counter < countermax)) begin
      counter_next = counter + 16'd1;
    end else begin
      // Advance: note expired or the sounding key was released.
      counter_next = 16'd0;
      if (!any_held) begin
        Next_State = IDLE;
        dir_next   = 1'b0;
      end else if (!PingPongEn) begin
        dir_next = 1'b0;
        // With nothing above n, wrap to the lowest held key (may be n itself).
        Next_State = {1'b0, (up_found ? up_idx : lo_idx)};
      end else if (!dir) begin
        if (up_found) begin
          Next_State = {1'b0, up_idx};
        end else if (dn_found) begin
          Next_State = {1'b0, dn_idx};
          dir_next   = 1'b1;
        end
      end else begin
        if (dn_found) begin
          Next_State = {1'b0, dn_idx};
        end else if (up_found) begin
          Next_State = {1'b0, up_idx};
          dir_next   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Curr_State <= IDLE;
      counter    <= 16'd0;
      dir        <= 1'b0;
    end else begin
      Curr_State <= Next_State;
      counter    <= counter_next;
      dir        <= dir_next;
    end
  end

  always_comb begin
    out_vec = 8'd0;
    if (!Enable) begin
      out_vec = keys;
    end else if (!Curr_State[3]) begin
      out_vec[Curr_State[2:0]] = 1'b1;
    end
  end

  assign {out7, out6, out5, out4, out3, out2, out1, out0} = out_vec;

  // NOTE0 documents the note encoding base; state values are the key index.
  logic unused_note0;
  assign unused_note0 = ^NOTE0;

endmodule

// File: tb/tb_arpeggiator.sv
// Self-checking bench for the arpeggiator. A set-based note model runs in
// lockstep with the DUT; directed scenarios also check against sequences
// written out directly from the note-order rules.
module tb_arpeggiator;

  logic        CLK;
  logic        RESET;
  logic        key0, key1, key2, key3, key4, key5, key6, key7;
  logic        Enable;
  logic        PingPongEn;
  logic [15:0] countermax;
  logic        out0, out1, out2, out3, out4, out5, out6, out7;

  logic [7:0] keys_v;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: m_state 8 = idle, else sounding key index.
  int m_state = 8;
  int m_cnt   = 0;
  bit m_dir   = 1'b0;

  assign {key7, key6, key5, key4, key3, key2, key1, key0} = keys_v;
  assign outs = {out7, out6, out5, out4, out3, out2, out1, out0};

  arpeggiator dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .key0      (key0),
    .key1      (key1),
    .key2      (key2),
    .key3      (key3),
    .key4      (key4),
    .key5      (key5),
    .key6      (key6),
    .key7      (key7),
    .Enable    (Enable),
    .PingPongEn(PingPongEn),
    .countermax(countermax),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_state = 8;
    m_cnt   = 0;
    m_dir   = 1'b0;
  endfunction

  // One clock edge of the note-order rules, using sets of held keys.
  function automatic void model_step();
    int above[$];
    int below[$];
    int held[$];
    if (RESET || !Enable) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 8; j++) begin
      if (keys_v[j]) begin
        held.push_back(j);
        if (m_state != 8 && j > m_state) above.push_back(j);
        if (m_state != 8 && j < m_state) below.push_back(j);
      end
    end
    if (m_state == 8) begin
      if (held.size() > 0) begin
        m_state = held[0];
        m_cnt   = 0;
        m_dir   = 1'b0;
      end
    end else if (keys_v[m_state] && m_cnt < int'(countermax)) begin
      m_cnt++;
    end else begin
      m_cnt = 0;
      if (held.size() == 0) begin
        m_state = 8;
        m_dir   = 1'b0;
      end else if (!PingPongEn) begin
        m_dir   = 1'b0;
        m_state = (above.size() > 0) ? above[0] : held[0];
      end else if (!m_dir) begin
        if (above.size() > 0) m_state = above[0];
        else if (below.size() > 0) begin
          m_state = below[below.size()-1];
          m_dir   = 1'b1;
        end
      end else begin
        if (below.size() > 0) m_state = below[below.size()-1];
        else if (above.size() > 0) begin
          m_state = above[0];
          m_dir   = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] model_out();
    if (!Enable) return keys_v;
    if (m_state == 8) return 8'd0;
    return 8'd1 << m_state;
  endfunction

  task automatic step();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Enable     = 1'b0;
    PingPongEn = 1'b0;
    countermax = 16'd0;
    keys_v     = 8'hFF;
    RESET      = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (outs !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_outs_during: got %h expected %h", outs, 8'hFF);
    end
    step();
    step();
    RESET = 1'b0;
    #1;
    n_checks++;
    if (outs !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_outs: got %h expected %h", outs, 8'hFF);
    end
    n_checks++;
    if (dut.Curr_State !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 8", dut.Curr_State);
    end
    n_checks++;
    if (dut.counter !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counter: got %0d expected 0", dut.counter);
    end
  endtask

  task automatic test_pingpong_all();
    int idx;
    int note;
    countermax = 16'd2;
    PingPongEn = 1'b1;
    keys_v     = 8'hFF;
    Enable     = 1'b0;
    step();
    Enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      // 0..7 then 6..1, period 14 notes, 3 cycles each.
      idx  = (c / 3) % 14;
      note = (idx <= 7) ? idx : 14 - idx;
      n_checks++;
      if (outs !== (8'd1 << note)) begin
        n_fail++;
        $display("FAIL pingpong_all c=%0d: got %h expected %h", c, outs, 8'd1 << note);
      end
      n_checks++;
      if (dut.counter !== 16'(c % 3)) begin
        n_fail++;
        $display("FAIL pingpong_cnt c=%0d: got %0d expected %0d", c, dut.counter, c % 3);
      end
    end
  endtask

  task automatic test_wrap_all();
    int note;
    countermax = 16'd2;
    PingPongEn = 1'b0;
    keys_v     = 8'hFF;
    Enable     = 1'b0;
    step();
    Enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      note = (c / 3) % 8;
      n_checks++;
      if (outs !== (8'd1 << note)) begin
        n_fail++;
        $display("FAIL wrap_all c=%0d: got %h expected %h", c, outs, 8'd1 << note);
      end
    end
  endtask

  task automatic test_two_keys();
    logic [7:0] exp;
    countermax = 16'd0;
    PingPongEn = 1'b1;
    keys_v     = 8'h24;
    Enable     = 1'b0;
    step();
    Enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      exp = (c % 2 == 0) ? 8'h04 : 8'h20;
      n_checks++;
      if (outs !== exp) begin
        n_fail++;
        $display("FAIL two_keys c=%0d: got %h expected %h", c, outs, exp);
      end
    end
  endtask

  task automatic test_release();
    countermax = 16'd5;
    PingPongEn = 1'b0;
    keys_v     = 8'hFF;
    Enable     = 1'b0;
    step();
    Enable = 1'b1;
    step();
    step();
    keys_v = 8'hFE;
    step();
    n_checks++;
    if (outs !== 8'h02) begin
      n_fail++;
      $display("FAIL release_next: got %h expected %h", outs, 8'h02);
    end
    n_checks++;
    if (dut.counter !== 16'd0) begin
      n_fail++;
      $display("FAIL release_cnt: got %0d expected 0", dut.counter);
    end
    keys_v = 8'h00;
    step();
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL release_all_outs: got %h expected 00", outs);
    end
    n_checks++;
    if (dut.Curr_State !== 4'd8) begin
      n_fail++;
      $display("FAIL release_all_state: got %0d expected 8", dut.Curr_State);
    end
  endtask

  task automatic test_reset_mid();
    countermax = 16'd3;
    PingPongEn = 1'b1;
    keys_v     = 8'h5A;
    Enable     = 1'b1;
    step();
    step();
    step();
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_outs: got %h expected 00", outs);
    end
    n_checks++;
    if (dut.Curr_State !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %0d expected 8", dut.Curr_State);
    end
    step();
    RESET = 1'b0;
    #1;
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %h expected 00", outs);
    end
    step();
    n_checks++;
    if (outs !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %h expected 02", outs);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5, 0) == 0) keys_v = 8'($urandom);
      if ($urandom_range(19, 0) == 0) PingPongEn = ~PingPongEn;
      if ($urandom_range(14, 0) == 0) countermax = 16'($urandom_range(4, 0));
      Enable = ($urandom_range(39, 0) != 0);
      step();
      exp = model_out();
      n_checks++;
      if (outs !== exp) begin
        n_fail++;
        $display("FAIL random_outs c=%0d: got %h expected %h", c, outs, exp);
      end
      n_checks++;
      if (dut.Curr_State !== 4'(m_state)) begin
        n_fail++;
        $display("FAIL random_state c=%0d: got %0d expected %0d", c, dut.Curr_State, m_state);
      end
      n_checks++;
      if (dut.counter !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_cnt c=%0d: got %0d expected %0d", c, dut.counter, m_cnt);
      end
    end
  endtask

  initial begin
    RESET      = 1'b1;
    Enable     = 1'b0;
    PingPongEn = 1'b0;
    countermax = 16'd0;
    keys_v     = 8'h00;
    test_reset();
    test_pingpong_all();
    test_wrap_all();
    test_two_keys();
    test_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arpeggiator.md
ARPEGGIATOR -- requirements
Module: arpeggiator

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports key0..key7  input  1 each  key-held flags; key0 = lowest note, key7 = highest.
REQ-004 SHALL have port Enable  input  1  1 = arpeggiate, 0 = pass-through.
REQ-005 SHALL have port PingPongEn  input  1  1 = up/down bounce, 0 = upward wrap.
REQ-006 SHALL have port countermax  input  16  note-hold length control (unsigned).
REQ-007 SHALL have ports out0..out7  output  1 each  note-on flags to the voice stage.
REQ-008 SHALL expose internal signals by these exact names for hierarchical probing: on0..on7, counter (at least 16 bits), Curr_State[3:0], Next_State[3:0].

Function
REQ-009 SHALL drive on_i = key_i combinationally (held-key mask).
REQ-010 SHALL implement Curr_State with 9 encodings: IDLE = 4'd8 and NOTE0..NOTE7 = 4'd0..4'd7 (index of the sounding key); Next_State is its combinational next value.
REQ-011 SHALL keep a 1-bit direction register dir (0 = up, 1 = down).
REQ-012 When Enable = 0: out_i = key_i combinationally; next state IDLE, counter 0, dir up.
REQ-013 When Enable = 1 and Curr_State = NOTEn: outn = 1, all other outs 0; in IDLE: all outs 0.
REQ-014 IDLE with Enable = 1: go to NOTEk for the lowest held key k on the next edge, counter 0, dir up; if no key held, stay IDLE.
REQ-015 In NOTEn, counter increments by 1 each cycle; when counter >= countermax, advance to the next note and clear counter; each note therefore lasts countermax+1 cycles (countermax = 0 gives 1 cycle per note).
REQ-016 Next note, PingPongEn = 0: nearest held key with index > n, wrapping 7 -> 0; dir stays up.
REQ-017 Next note, PingPongEn = 1: nearest held key in direction dir; if none exists before the end (index 7 going up, index 0 going down), toggle dir and take the nearest held key in the new direction; endpoints are not repeated.
REQ-018 If n is the only held key, remain in NOTEn with counter cleared at each expiry.
REQ-019 If key_n of the sounding note is released, advance on the next edge regardless of counter, using REQ-016/017; if no keys are held, go to IDLE.
REQ-020 Keys pressed or released mid-sequence take effect at the next advance decision; no restart.
REQ-021 Changing PingPongEn mid-sequence applies at the next advance; when switching to 0, dir forced up.
REQ-022 countermax is sampled continuously; reducing it below counter triggers an advance on the next edge.

Reset
REQ-023 RESET = 1 SHALL asynchronously force Curr_State = IDLE, counter = 0, dir = up.
REQ-024 During and after reset, outputs follow REQ-012/013: out_i = key_i if Enable = 0, else all 0 until the first note state.
REQ-025 Reset asserted mid-sequence SHALL abort immediately; after release, sequence restarts from the lowest held key per REQ-014.

Verification
REQ-026 RESET pulse, Enable = 0, all keys = 1 -> out0..out7 all 1, Curr_State = 8, counter = 0.
REQ-027 countermax = 2, PingPongEn = 1, all keys held, Enable 0 -> 1 -> notes 0,1,...,7,6,...,1,0,1... each exactly 3 cycles, exactly one out high.
REQ-028 countermax = 2, PingPongEn = 0, all keys held -> notes 0..7 then 0 again, 3 cycles each.
REQ-029 Only key2 and key5 held, PingPongEn = 1, countermax = 0 -> out2/out5 alternate every cycle.
REQ-030 Release the sounding key mid-note -> next held key asserted on the next edge; release all keys -> all outs 0, Curr_State = 8.
REQ-031 Assert RESET mid-note with Enable = 1 -> all outs 0 immediately; after release, out of the lowest held key asserts one cycle later.
